// File: rtl/seq_parser_mstream.sv
// seq_parser_mstream
// Parses length-prefixed packets that arrive as 32-bit beats. Each packet
// belongs to one of NUM_STREAMS streams, and the parser keeps a 32-bit
// sequence number for every stream. For each packet it reports gaps,
// reordering or duplicates, and format errors. Parsed packets wait in a
// two-entry output buffer, so reception continues while one packet waits
// for the consumer.
//
// Ports:
//   clk            clock, rising edge
//   reset_b        asynchronous active-low reset
//   dataIn         input beat, first wire byte in [31:24]
//   dataIn_val     input beat valid
//   dataIn_ready   parser can accept a beat (output buffer not full)
//   dataIN_last    final beat of the packet
//   dataOut        payload, first byte in the MSBs, zero-padded
//   dataOut_val    output packet valid
//   dataOut_ready  consumer takes the head packet
//   dataOut_bytes  number of payload bytes stored
//   dataOut_stream stream id of the packet
//   packetLost     gap detected before this packet
//   lostCount      number of missing sequence numbers
//   seqError       duplicate or out-of-order sequence number
//   fmtError       malformed packet
module seq_parser_mstream #(
    parameter int  NUM_STREAMS       = 32,
    parameter int  MAX_PAYLOAD_BYTES = 37,
    localparam int STREAM_W          = $clog2(NUM_STREAMS)
) (
    input  logic                           clk,
    input  logic                           reset_b,
    input  logic [31:0]                    dataIn,
    input  logic                           dataIn_val,
    output logic                           dataIn_ready,
    input  logic                           dataIN_last,
    output logic [MAX_PAYLOAD_BYTES*8-1:0] dataOut,
    output logic                           dataOut_val,
    input  logic                           dataOut_ready,
    output logic [15:0]                    dataOut_bytes,
    output logic [STREAM_W-1:0]            dataOut_stream,
    output logic                           packetLost,
    output logic [31:0]                    lostCount,
    output logic                           seqError,
    output logic                           fmtError
);

    localparam int          PW       = MAX_PAYLOAD_BYTES * 8;
    localparam logic [15:0] MAX_B    = 16'(MAX_PAYLOAD_BYTES);
    localparam logic [15:0] NUM_S    = 16'(NUM_STREAMS);

    typedef enum logic [1:0] {HDR0 = 2'd0, HDR1 = 2'd1, DATA = 2'd2} state_t;

    typedef struct packed {
        logic [PW-1:0]       payload;
        logic [15:0]         bytes;
        logic [STREAM_W-1:0] stream;
        logic                lost;
        logic [31:0]         lost_count;
        logic                seq_err;
        logic                fmt_err;
    } entry_t;

    // Parser state
    state_t        state_r;
    logic [15:0]   len_r;
    logic [15:0]   sid_r;
    logic [31:0]   seq_r;
    logic [15:0]   rem_r;      // payload bytes still expected
    logic [15:0]   cons_r;     // payload bytes already consumed
    logic          fmt_r;      // format error seen so far in this packet
    logic [PW-1:0] pack_r;

    // Stream table
    logic [31:0]   last_tab_r [NUM_STREAMS];
    logic          seen_r     [NUM_STREAMS];

    // Output buffer: ent0_r is the head
    entry_t        ent0_r;
    entry_t        ent1_r;
    logic [1:0]    cnt_r;
    logic          val_r;
    logic          rdy_r;

    // Combinational helpers
    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic [1:0]          cnt_n_s;
    logic [15:0]         len_s;
    logic [15:0]         sid_s;
    logic [31:0]         seq_s;
    logic [2:0]          keep_s;
    logic [PW-1:0]       pack_n_s;
    logic [STREAM_W-1:0] tab_idx_s;
    logic [31:0]         diff_s;
    logic                seen_s;
    logic                fmt_fin_s;
    logic                tab_wr_s;
    entry_t              new_s;

    assign accept_s  = dataIn_val & rdy_r;
    assign push_s    = accept_s & dataIN_last;
    assign pop_s     = val_r & dataOut_ready;

    // Header fields are little-endian on the wire, so swap the bytes
    assign len_s     = {dataIn[23:16], dataIn[31:24]};
    assign sid_s     = {dataIn[7:0], dataIn[15:8]};
    assign seq_s     = {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]};

    assign tab_idx_s = sid_r[STREAM_W-1:0];
    assign seen_s    = seen_r[tab_idx_s];
    assign diff_s    = seq_r - (last_tab_r[tab_idx_s] + 32'd1);

    // The last data beat is well formed only if 1..4 bytes remain
    assign fmt_fin_s = fmt_r | (rem_r == 16'd0) | (rem_r > 16'd4);

    // Bytes taken from the current beat, and the packing register after that beat
    always_comb begin
        pack_n_s = pack_r;
        if (rem_r >= 16'd4) begin
            keep_s = 3'd4;
        end else begin
            keep_s = rem_r[2:0];
        end
        for (int k = 0; k < 4; k++) begin
            if ((k < int'(keep_s)) && ((int'(cons_r) + k) < MAX_PAYLOAD_BYTES)) begin
                pack_n_s[(MAX_PAYLOAD_BYTES - 1 - int'(cons_r) - k) * 8 +: 8] = dataIn[(3 - k) * 8 +: 8];
            end else begin
                pack_n_s = pack_n_s;
            end
        end
    end

    // Build the output entry and decide on the table write for a packet ending this cycle
    always_comb begin
        new_s    = '0;
        tab_wr_s = 1'b0;
        case (state_r)
            HDR0: begin
                new_s.fmt_err = 1'b1;
            end
            HDR1: begin
                new_s.fmt_err = 1'b1;
                new_s.stream  = sid_r[STREAM_W-1:0];
            end
            DATA: begin
                new_s.stream = sid_r[STREAM_W-1:0];
                if (fmt_fin_s) begin
                    new_s.fmt_err = 1'b1;
                end else begin
                    new_s.payload = pack_n_s;
                    new_s.bytes   = len_r - 16'd8;
                    if (!seen_s || (diff_s == 32'd0)) begin
                        tab_wr_s = 1'b1;
                    end else if (!diff_s[31]) begin
                        tab_wr_s         = 1'b1;
                        new_s.lost       = 1'b1;
                        new_s.lost_count = diff_s;
                    end else begin
                        new_s.seq_err = 1'b1;
                    end
                end
            end
            default: begin
                new_s.fmt_err = 1'b1;
            end
        endcase
    end

    // Packet parser FSM: header capture, payload packing, format tracking
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r <= HDR0;
            len_r   <= 16'd0;
            sid_r   <= 16'd0;
            seq_r   <= 32'd0;
            rem_r   <= 16'd0;
            cons_r  <= 16'd0;
            fmt_r   <= 1'b0;
            pack_r  <= '0;
        end else if (accept_s) begin
            case (state_r)
                HDR0: begin
                    if (!dataIN_last) begin
                        len_r   <= len_s;
                        sid_r   <= sid_s;
                        fmt_r   <= (len_s < 16'd8) | (len_s > (MAX_B + 16'd8)) | (sid_s >= NUM_S);
                        rem_r   <= (len_s < 16'd8) ? 16'd0 : (len_s - 16'd8);
                        cons_r  <= 16'd0;
                        pack_r  <= '0;
                        state_r <= HDR1;
                    end
                end
                HDR1: begin
                    seq_r   <= seq_s;
                    state_r <= dataIN_last ? HDR0 : DATA;
                end
                DATA: begin
                    pack_r <= pack_n_s;
                    cons_r <= cons_r + {13'd0, keep_s};
                    rem_r  <= rem_r - {13'd0, keep_s};
                    if (dataIN_last) begin
                        state_r <= HDR0;
                    end else if (rem_r <= 16'd4) begin
                        // payload exhausted but the packet keeps going
                        fmt_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= HDR0;
                end
            endcase
        end
    end

    // Per-stream table of last accepted sequence number and seen bit
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                last_tab_r[i] <= 32'd0;
                seen_r[i]     <= 1'b0;
            end
        end else if (push_s && tab_wr_s) begin
            last_tab_r[tab_idx_s] <= seq_r;
            seen_r[tab_idx_s]     <= 1'b1;
        end
    end

    // Next occupancy of the output buffer
    always_comb begin
        cnt_n_s = cnt_r;
        if (push_s && !pop_s) begin
            cnt_n_s = cnt_r + 2'd1;
        end else if (pop_s && !push_s) begin
            cnt_n_s = cnt_r - 2'd1;
        end else begin
            cnt_n_s = cnt_r;
        end
    end

    // Two-entry output buffer; empty slots are kept at zero so idle outputs read 0
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ent0_r <= '0;
            ent1_r <= '0;
            cnt_r  <= 2'd0;
            val_r  <= 1'b0;
            rdy_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                if (cnt_r == 2'd2) begin
                    ent0_r <= ent1_r;
                end else if (push_s) begin
                    ent0_r <= new_s;
                end else begin
                    ent0_r <= '0;
                end
                ent1_r <= '0;
            end else if (push_s) begin
                if (cnt_r == 2'd0) begin
                    ent0_r <= new_s;
                end else begin
                    ent1_r <= new_s;
                end
            end
            cnt_r <= cnt_n_s;
            val_r <= (cnt_n_s != 2'd0);
            rdy_r <= (cnt_n_s != 2'd2);
        end
    end

    assign dataIn_ready   = rdy_r;
    assign dataOut_val    = val_r;
    assign dataOut        = ent0_r.payload;
    assign dataOut_bytes  = ent0_r.bytes;
    assign dataOut_stream = ent0_r.stream;
    assign packetLost     = ent0_r.lost;
    assign lostCount      = ent0_r.lost_count;
    assign seqError       = ent0_r.seq_err;
    assign fmtError       = ent0_r.fmt_err;

endmodule

// File: doc/seq_parser_mstream.md
Name: seq_parser_mstream

Overview:
- Generalised successor of the single-stream sequence parser.
- Receives length-prefixed packets as 32-bit beats over a val/ready/last interface and tracks a per-stream 32-bit sequence number for NUM_STREAMS streams.
- Reports loss count, reorder/duplicate and format errors per packet.
- Presents the zero-padded payload on a wide output behind a two-entry output buffer, so reception continues while one packet awaits the consumer.

Parameters:
- NUM_STREAMS, 32: number of tracked streams; valid stream ids are 0..NUM_STREAMS-1.
- MAX_PAYLOAD_BYTES, 37: output payload capacity in bytes; dataOut width is MAX_PAYLOAD_BYTES*8.
- STREAM_W, $clog2(NUM_STREAMS) (derived localparam): width of dataOut_stream.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_b  in  1  asynchronous active-low reset.
- dataIn  in  32  input beat; first wire byte is [31:24].
- dataIn_val  in  1  input beat valid.
- dataIn_ready  out  1  parser accepts a beat when dataIn_val & dataIn_ready.
- dataIN_last  in  1  marks the final beat of a packet.
- dataOut  out  MAX_PAYLOAD_BYTES*8  payload, first byte in the MSBs, zero-padded.
- dataOut_val  out  1  output packet valid.
- dataOut_ready  in  1  consumer accepts the packet when dataOut_val & dataOut_ready.
- dataOut_bytes  out  16  payload byte count actually stored (0..MAX_PAYLOAD_BYTES).
- dataOut_stream  out  STREAM_W  stream id of the packet.
- packetLost  out  1  gap detected before this packet.
- lostCount  out  32  number of missing sequence numbers (0 if none).
- seqError  out  1  duplicate or out-of-order sequence number.
- fmtError  out  1  malformed packet.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs are 0 and the output buffer is empty.
  - The stream table (last seq plus seen bit per stream) is cleared.
  - The parser enters HDR0.
  - Any partial packet is discarded; after release the next accepted beat is treated as a header.
- Header decoding (byte-swapped little-endian fields):
  - Beat 0: len = {dataIn[23:16], dataIn[31:24]} is the total bytes including the 8-byte header; sid = {dataIn[7:0], dataIn[15:8]}.
  - Beat 1: seq = {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]}.
- Parser states:
  - HDR0 -> HDR1 on an accepted beat.
  - HDR1 -> DATA on an accepted beat.
  - DATA -> HDR0 on an accepted beat with dataIN_last.
  - dataIN_last on an accepted beat in HDR0 or HDR1: emit the packet with fmtError=1, dataOut_bytes=0, stream id = sid if latched else 0; return to HDR0.
- Payload storage:
  - Payload beats are written MSB-first into the packing register.
  - On the last beat only the first remaining (len-8 minus bytes already consumed) bytes are kept, 1..4; the lower bytes are zeroed.
  - Bytes beyond MAX_PAYLOAD_BYTES are discarded.
- fmtError=1 when any of these hold:
  - len < 8;
  - len-8 > MAX_PAYLOAD_BYTES;
  - sid >= NUM_STREAMS;
  - dataIN_last arrives when the remaining bytes are not in 1..4;
  - the remaining bytes reach 0 without dataIN_last (further beats are absorbed until last).
- On a fmtError packet: the stream table is not updated, and packetLost, seqError and lostCount are 0.
- Sequence check (at the last beat, sid valid, no fmtError):
  - If the stream is not yet seen: no flags; load the table and set seen.
  - Otherwise diff = seq - (last+1), mod 2^32:
    - diff == 0: clean packet.
    - 0 < diff < 2^31: packetLost=1, lostCount=diff; the table is updated.
    - diff >= 2^31: seqError=1; the table is not updated.
  - Wrap: last=0xFFFFFFFF followed by seq=0 is clean.
- Output buffer:
  - Two-entry FIFO of {payload, bytes, stream, flags}.
  - A packet is pushed on the edge that accepts its last beat; dataOut_val rises the next cycle.
  - dataIn_ready = (entries < 2). It has no combinational path from dataOut_ready.
  - Outputs show the head entry and are held stable while dataOut_val & !dataOut_ready.
  - dataOut and all flags are 0 when dataOut_val=0.
  - A simultaneous push and pop keeps the entry count unchanged and preserves order.
- Same-stream back-to-back packets: the table write at one packet's last beat is visible to the next packet's check.

Test Plan:
- Stream 3, seq 5 then seq 6, payload 0xAABBCCDD -> both packets clean; second dataOut[top 32]=0xAABBCCDD, dataOut_bytes=4, remaining bits 0.
- Stream 3: seq 6 then seq 10 -> packetLost=1, lostCount=3; then seq 9 -> seqError=1 and the table still holds 10.
- len=8+5 with beats 0x11223344, 0x55667788 -> dataOut top 40 bits = 0x1122334455, bytes=5, remaining bits 0.
- dataOut_ready held low over 3 packets -> dataIn_ready drops after the 2nd last beat; the 3rd is accepted once the 1st pops; output order preserved.
- Error cases:
  - len=8+40 -> fmtError=1, bytes=0, later packets unaffected.
  - sid=40 -> fmtError=1.
  - last on beat 1 -> fmtError=1, bytes=0.
- reset_b pulsed low mid-payload and with a full buffer -> dataOut_val=0 immediately; the next packet's first sighting of each stream raises no flags.
